// File: rtl/rr_encoder_pend.sv
// Round-robin pending-request encoder: merges one-hot request pulses into a pending
// vector and hands them out as binary indices over a valid/ready handshake.
module rr_encoder_pend #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req_in,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic [W-1:0] ptr_q, ptr_d;

    // First set bit at or above p; otherwise wrap to the lowest set bit.
    function automatic logic [W-1:0] rr_select(input logic [N-1:0] v, input logic [W-1:0] p);
        logic         found_hi;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        found_hi = 1'b0;
        hi       = '0;
        lo       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                lo = W'(i);
                if (W'(i) >= p) begin
                    hi       = W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        return found_hi ? hi : lo;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (W'(i) == idx);
        end
        return r;
    endfunction

    always_comb begin
        logic [N-1:0] rem;
        logic [W-1:0] ptr_nxt;
        logic [W-1:0] sel;
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        ptr_d     = ptr_q;
        rem       = '0;
        ptr_nxt   = ptr_q;
        sel       = '0;

        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
            onehot_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pending_d = pending_q | req_in;
                    if (pending_q != '0) begin
                        sel      = rr_select(pending_q, ptr_q);
                        idx_d    = sel;
                        onehot_d = to_onehot(sel);
                        state_d  = PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        // Selection sees only what was pending before this edge; same-edge
                        // requests (even for the consumed bit) re-enter via pending_d.
                        ptr_nxt   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        ptr_d     = ptr_nxt;
                        rem       = pending_q & ~onehot_q;
                        pending_d = rem | req_in;
                        if (rem != '0) begin
                            sel      = rr_select(rem, ptr_nxt);
                            idx_d    = sel;
                            onehot_d = to_onehot(sel);
                        end else begin
                            onehot_d = '0;
                            state_d  = IDLE;
                        end
                    end else begin
                        pending_d = pending_q | req_in;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    onehot_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            onehot_q  <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid  = (state_q == PRESENT);
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign pending    = pending_q;

    // The presented index must always still be pending.
    a_presented_pending : assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == PRESENT) |-> pending_q[idx_q]
    );

endmodule

// File: tb/tb_rr_encoder_pend.sv
// Directed bench for rr_encoder_pend: reset, latency, round-robin order, stall,
// same-edge re-request, flush and asynchronous reset.
module tb_rr_encoder_pend;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk;
    logic         resetn;
    logic [N-1:0] req_in;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic [N-1:0] pending;

    int n_assert;
    int n_fail;

    rr_encoder_pend #(.N(N), .W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_in    (req_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_onehot(out_onehot),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit for sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W-1:0] idx,
                           input logic [N-1:0] pend);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
            chk({tag, "_onehot"}, 32'(out_onehot), 32'(16'h0001 << idx));
        end else begin
            chk({tag, "_onehot"}, 32'(out_onehot), 32'h0);
        end
        chk({tag, "_pend"}, 32'(pending), 32'(pend));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #2;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        req_in    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset held 3 cycles with random requests
        for (int i = 0; i < 3; i++) begin
            req_in = 16'($urandom);
            tick();
            chk("rst_valid", 32'(out_valid), 32'h0);
            chk("rst_idx", 32'(out_idx), 32'h0);
            chk("rst_pend", 32'(pending), 32'h0);
            chk("rst_onehot", 32'(out_onehot), 32'h0);
        end
        req_in = '0;
        #2;
        resetn = 1'b1;
        tick();

        // Single request: valid two edges after sampling
        out_ready = 1'b1;
        req_in    = 16'h0020;
        tick();
        req_in = '0;
        chk_out("t2_e0", 1'b0, 4'd0, 16'h0020);
        tick();
        chk_out("t2_e1", 1'b1, 4'd5, 16'h0020);
        tick();
        chk_out("t2_e2", 1'b0, 4'd0, 16'h0000);

        // Burst 0,5,10,15 then wrap to 0,1
        do_reset();
        out_ready = 1'b1;
        req_in    = 16'h8421;
        tick();
        req_in = '0;
        tick();
        chk_out("t3_a", 1'b1, 4'd0, 16'h8421);
        tick();
        chk_out("t3_b", 1'b1, 4'd5, 16'h8420);
        tick();
        chk_out("t3_c", 1'b1, 4'd10, 16'h8400);
        tick();
        chk_out("t3_d", 1'b1, 4'd15, 16'h8000);
        tick();
        chk_out("t3_e", 1'b0, 4'd0, 16'h0000);
        req_in = 16'h0003;
        tick();
        req_in = '0;
        tick();
        chk_out("t3_f", 1'b1, 4'd0, 16'h0003);
        tick();
        chk_out("t3_g", 1'b1, 4'd1, 16'h0002);
        tick();
        chk_out("t3_h", 1'b0, 4'd0, 16'h0000);

        // Stall for 10 cycles with a new request arriving mid-way
        do_reset();
        out_ready = 1'b0;
        req_in    = 16'h0006;
        tick();
        req_in = '0;
        tick();
        chk_out("t4_first", 1'b1, 4'd1, 16'h0006);
        for (int i = 0; i < 10; i++) begin
            req_in = (i == 4) ? 16'h0001 : 16'h0000;
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'h1);
            chk("t4_hold_idx", 32'(out_idx), 32'd1);
        end
        req_in = '0;
        chk("t4_pend", 32'(pending), 32'h0007);
        out_ready = 1'b1;
        tick();
        chk_out("t4_a", 1'b1, 4'd2, 16'h0005);
        tick();
        chk_out("t4_b", 1'b1, 4'd0, 16'h0001);
        tick();
        chk_out("t4_c", 1'b0, 4'd0, 16'h0000);

        // Re-request of the consumed index on the handshake edge
        do_reset();
        out_ready = 1'b0;
        req_in    = 16'h0084;
        tick();
        req_in = '0;
        tick();
        chk_out("t5_a", 1'b1, 4'd2, 16'h0084);
        out_ready = 1'b1;
        req_in    = 16'h0004;
        tick();
        req_in = '0;
        chk_out("t5_b", 1'b1, 4'd7, 16'h0084);
        tick();
        chk_out("t5_c", 1'b1, 4'd2, 16'h0004);
        tick();
        chk_out("t5_d", 1'b0, 4'd0, 16'h0000);

        // Flush wins over handshake and same-edge request
        out_ready = 1'b0;
        req_in    = 16'h0008;
        tick();
        req_in = '0;
        tick();
        chk_out("t6_pre", 1'b1, 4'd3, 16'h0008);
        out_ready = 1'b1;
        flush     = 1'b1;
        req_in    = 16'h0010;
        tick();
        flush  = 1'b0;
        req_in = '0;
        chk_out("t6_flush", 1'b0, 4'd0, 16'h0000);
        chk("t6_idx_kept", 32'(out_idx), 32'd3);
        tick();
        chk_out("t6_after", 1'b0, 4'd0, 16'h0000);

        // Asynchronous reset mid-presentation
        out_ready = 1'b0;
        req_in    = 16'h0040;
        tick();
        req_in = '0;
        tick();
        chk_out("t6_pre2", 1'b1, 4'd6, 16'h0040);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(out_valid), 32'h0);
        chk("t6_arst_idx", 32'(out_idx), 32'h0);
        chk("t6_arst_onehot", 32'(out_onehot), 32'h0);
        chk("t6_arst_pend", 32'(pending), 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
